// File: rtl/fmap_stream_out.sv
// Captures a complete flattened feature map on start and replays it
// row-major as a valid/ready stream tagged with row/col and end flags.
module fmap_stream_out #(
    parameter int DATA_WIDTH = 32,
    parameter int H          = 28,
    parameter int W          = 28
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [0:H*W*DATA_WIDTH-1]    fmap,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [5:0]                   m_row,
    output logic [5:0]                   m_col,
    output logic                         m_eol,
    output logic                         m_last,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned N  = H * W;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q     [N];
    logic [DATA_WIDTH-1:0]   fmap_elem [N];
    logic [5:0]              row_q, row_d;
    logic [5:0]              col_q, col_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    capture;
    logic                    at_eol;
    logic                    at_last;
    logic                    streaming;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign fmap_elem[g] = fmap[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign at_eol    = (col_q == 6'(W - 1));
    assign at_last   = at_eol && (row_q == 6'(H - 1));
    assign streaming = (state_q == STREAM);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (m_ready) begin
                    // A flat element index runs alongside row/col so the
                    // buffer read needs no row*W multiplier.
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (at_eol) begin
                            col_d = '0;
                            row_d = row_q + 6'd1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end
                end
            end
            DONE: begin
                row_d   = '0;
                col_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (capture) begin
            mem_q <= fmap_elem;
        end
    end

    always_comb begin
        m_valid = streaming;
        m_data  = streaming ? mem_q[idx_q] : '0;
        m_row   = row_q;
        m_col   = col_q;
        m_eol   = streaming && at_eol;
        m_last  = streaming && at_last;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
    end

endmodule

// File: tb/tb_fmap_stream_out.sv
// Bench for fmap_stream_out: a 3x4 instance driven by vector tables, hand
// sequences and random backpressure against a queue model, plus a 1x1 instance.
module tb_fmap_stream_out;

    localparam int DW = 8;
    localparam int H  = 3;
    localparam int W  = 4;
    localparam int N  = H * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, m_ready;
    logic [0:N*DW-1]   fmap;
    logic              m_valid, m_eol, m_last, busy, done;
    logic [DW-1:0]     m_data;
    logic [5:0]        m_row, m_col;

    logic              start1, ready1;
    logic [0:DW-1]     fmap1;
    logic              valid1, eol1, last1, busy1, done1;
    logic [DW-1:0]     data1;
    logic [5:0]        row1, col1;

    fmap_stream_out #(.DATA_WIDTH(DW), .H(H), .W(W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .fmap(fmap),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_eol(m_eol), .m_last(m_last),
        .busy(busy), .done(done)
    );

    fmap_stream_out #(.DATA_WIDTH(DW), .H(1), .W(1)) u_one (
        .clk(clk), .reset(reset), .start(start1), .fmap(fmap1),
        .m_valid(valid1), .m_ready(ready1), .m_data(data1),
        .m_row(row1), .m_col(col1), .m_eol(eol1), .m_last(last1),
        .busy(busy1), .done(done1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int data;
        int row;
        int col;
        bit eol;
        bit last;
    } elem_t;

    elem_t exp_q[$];
    int    map_m[N];

    task automatic load_map(input int base);
        for (int k = 0; k < N; k++) begin
            map_m[k] = (k + base) & 255;
            fmap     = {fmap[DW:N*DW-1], 8'(k + base)};
        end
    endtask

    task automatic push_expected();
        exp_q.delete();
        for (int k = 0; k < N; k++)
            exp_q.push_back('{data: map_m[k], row: k / W, col: k % W,
                              eol: (k % W) == W - 1, last: k == N - 1});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge right after the start edge; returns at the done cycle.
    task automatic run_stream(input int pct, input int ign_at, input bit check_period);
        int    cyc  = 0;
        int    sent = 0;
        elem_t e;
        while (exp_q.size() > 0 && cyc < 200) begin
            e = exp_q[0];
            chk("valid", m_valid, 1);
            chk("data",  m_data,  e.data);
            chk("row",   m_row,   e.row);
            chk("col",   m_col,   e.col);
            chk("eol",   m_eol,   e.eol);
            chk("last",  m_last,  e.last);
            chk("busy",  busy,    1);
            m_ready = ($urandom_range(99) < pct);
            if (sent == ign_at) begin
                start = 1'b1;
                fmap  = '1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            if (m_ready) begin
                void'(exp_q.pop_front());
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (exp_q.size() > 0) chk("stream_timeout", exp_q.size(), 0);
        chk("done_pulse", done,    1);
        chk("done_valid", m_valid, 0);
        chk("done_busy",  busy,    1);
        if (check_period) chk("stream_cycles", cyc, N);
    endtask

    typedef struct {
        bit rdy;
        bit vld;
        int data;
        int row;
        int col;
        bit eol;
        bit last;
        bit dn;
        bit bsy;
    } vec_t;

    vec_t tv[17];

    initial begin
        // map k+1; three-cycle stall on element 6 (row1,col1)
        tv[0]  = '{1, 1,  1, 0, 0, 0, 0, 0, 1};
        tv[1]  = '{1, 1,  2, 0, 1, 0, 0, 0, 1};
        tv[2]  = '{1, 1,  3, 0, 2, 0, 0, 0, 1};
        tv[3]  = '{1, 1,  4, 0, 3, 1, 0, 0, 1};
        tv[4]  = '{1, 1,  5, 1, 0, 0, 0, 0, 1};
        tv[5]  = '{0, 1,  6, 1, 1, 0, 0, 0, 1};
        tv[6]  = '{0, 1,  6, 1, 1, 0, 0, 0, 1};
        tv[7]  = '{0, 1,  6, 1, 1, 0, 0, 0, 1};
        tv[8]  = '{1, 1,  6, 1, 1, 0, 0, 0, 1};
        tv[9]  = '{1, 1,  7, 1, 2, 0, 0, 0, 1};
        tv[10] = '{1, 1,  8, 1, 3, 1, 0, 0, 1};
        tv[11] = '{1, 1,  9, 2, 0, 0, 0, 0, 1};
        tv[12] = '{1, 1, 10, 2, 1, 0, 0, 0, 1};
        tv[13] = '{1, 1, 11, 2, 2, 0, 0, 0, 1};
        tv[14] = '{1, 1, 12, 2, 3, 1, 1, 0, 1};
        tv[15] = '{1, 0,  0, 0, 0, 0, 0, 1, 1};
        tv[16] = '{1, 0,  0, 0, 0, 0, 0, 0, 0};

        reset = 1'b1; start = 1'b0; m_ready = 1'b0; fmap = '0;
        start1 = 1'b0; ready1 = 1'b0; fmap1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", m_valid, 0); chk("rst_data", m_data, 0);
        chk("rst_row", m_row, 0);     chk("rst_col", m_col, 0);
        chk("rst_eol", m_eol, 0);     chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst1_valid", valid1, 0); chk("rst1_busy", busy1, 0);
        reset = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_valid", m_valid, 0);

        load_map(1);
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            chk("tv_valid", m_valid, tv[i].vld);
            chk("tv_data",  m_data,  tv[i].data);
            chk("tv_row",   m_row,   tv[i].row);
            chk("tv_col",   m_col,   tv[i].col);
            chk("tv_eol",   m_eol,   tv[i].eol);
            chk("tv_last",  m_last,  tv[i].last);
            chk("tv_done",  done,    tv[i].dn);
            chk("tv_busy",  busy,    tv[i].bsy);
            m_ready = tv[i].rdy;
            @(negedge clk);
        end

        // capture isolation, ignored start at element 5, then back-to-back restart
        load_map(1);
        push_expected();
        pulse_start();
        fmap = '1;
        run_stream(100, 4, 1);
        @(negedge clk);
        load_map(101);
        push_expected();
        pulse_start();
        run_stream(100, -1, 1);
        @(negedge clk);
        chk("post_idle_busy", busy, 0);

        // asynchronous reset mid-stream
        load_map(1);
        pulse_start();
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_data", m_data, 7);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", m_valid, 0); chk("arst_data", m_data, 0);
        chk("arst_row", m_row, 0);     chk("arst_col", m_col, 0);
        chk("arst_eol", m_eol, 0);     chk("arst_last", m_last, 0);
        chk("arst_busy", busy, 0);     chk("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", m_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        push_expected();
        pulse_start();
        run_stream(100, -1, 1);

        // random backpressure over five back-to-back maps
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            load_map(int'($urandom_range(255)));
            push_expected();
            pulse_start();
            run_stream(50, -1, 0);
        end

        // 1x1 map
        fmap1 = 8'hA5;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (2) begin
            chk("one_valid", valid1, 1); chk("one_data", data1, 8'hA5);
            chk("one_row", row1, 0);     chk("one_col", col1, 0);
            chk("one_eol", eol1, 1);     chk("one_last", last1, 1);
            chk("one_done_early", done1, 0);
            @(negedge clk);
        end
        ready1 = 1'b1;
        @(negedge clk);
        chk("one_done", done1, 1); chk("one_done_valid", valid1, 0); chk("one_done_busy", busy1, 1);
        @(negedge clk);
        chk("one_idle_done", done1, 0); chk("one_idle_busy", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
